freq_ascii_framer: RTL
======================

# freq_ascii_framer

- Sits between the frequency-measurement core and the UART byte transmitter.
- On a start pulse it captures one frequency/duty result and converts both fields to fixed-width ASCII decimal with a sequential shift-add-3 converter.
- It then streams a 24-byte text frame over a valid/ready byte interface.
- The host or a terminal reads the measured values directly off the serial line.

## Interface
Parameters:
- FREQ_W, 34: frequency input width in bits.
- DUTY_W, 8: duty input width in bits.
- FREQ_DIGITS, 11: decimal digits printed for frequency; must cover 2^FREQ_W-1.
- DUTY_DIGITS, 3: decimal digits printed for duty.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  single-cycle request to format and send one frame.
- freq  in  FREQ_W  measured frequency in Hz, unsigned.
- duty  in  DUTY_W  measured duty cycle in percent, unsigned, printed raw.
- busy  out  1  high while a frame is converting or emitting.
- tx_data  out  8  ASCII byte to the transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  the transmitter accepts tx_data this cycle.

## Operation
- Frame, 24 bytes: "F=" + 11 freq digits + "Hz D=" + 3 duty digits + "%" + CR (0x0D) + LF (0x0A).
- Capture rule:
  - In IDLE, start=1 latches freq and duty into internal registers.
  - Later changes on freq and duty do not affect the frame in flight.
- States and transitions:
  - IDLE: start=1 goes to CONV_F.
  - CONV_F: converts the captured freq; goes to CONV_D after FREQ_W cycles.
  - CONV_D: converts the captured duty; goes to EMIT after DUTY_W cycles.
  - EMIT: sends the frame bytes; after byte 23 handshakes, returns to IDLE.
- Conversion: double-dabble, one bit per cycle.
  - Before each shift, every BCD nibble that is at least 5 gets 3 added.
  - The BCD register width is 4×digits. There is no overflow, because the digit counts cover each input's maximum value.
- Emit:
  - A byte index counts 0..23 and advances only on tx_valid & tx_ready.
  - tx_data is a combinational mux of the index over the constant characters and the digit nibbles + 0x30, registered into tx_data.
- Duty above 100 is printed as-is; the maximum is "255".
- start while busy is ignored. There is no queueing and no error flag.
- Reset mid-operation: rst_n low at any edge forces IDLE, clears the index and drops tx_valid. Any partial frame is abandoned.

## Timing
- Reset values: busy=0, tx_valid=0, tx_data=0x00.
- All internal registers reset: index=0, BCD registers=0.
- Start sampled at edge N:
  - busy=1 from N+1.
  - CONV_F occupies N+1..N+34.
  - CONV_D occupies N+35..N+42.
  - tx_valid=1 with byte 0 ("F") from N+43.
- Start-to-first-byte latency is 43 cycles.
- Handshake rules:
  - A transfer occurs on an edge where tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data stays stable and tx_valid stays high.
- With tx_ready held high, the 24 bytes go out on 24 consecutive cycles.
- After the byte-23 handshake edge, the next cycle shows tx_valid=0 and busy=0.
- start in that first idle cycle is accepted.
- start on the same edge as the byte-23 handshake is ignored, because the block is still busy.

## Configuration
- Macro: FREQ_ZERO_SUPPRESS_EN.
- Defined: leading zero digits of the frequency field are emitted as ASCII space (0x20).
  - The least significant digit is always numeric.
  - Frame length and timing are unchanged.
  - The duty field is never suppressed.
- Undefined: all frequency digits are emitted as numerals, zero-padded to 11 digits.

## Structure
- Package freq_fmt_pkg holds:
  - the state enum (IDLE, CONV_F, CONV_D, EMIT);
  - FRAME_LEN=24;
  - the ASCII constants for "F", "=", "H", "z", space, "D", "%", CR, LF and "0".
- Sub-module bin2bcd_seq:
  - a width-parameterised sequential double-dabble converter;
  - signals: load, busy/done, bcd output;
  - one instance, reused for freq then duty; the duty BCD is stored separately.

## Test plan
- freq=50_000_000, duty=50, tx_ready=1 → frame "F=00050000000Hz D=050%\r\n".
  - First tx_valid exactly 43 cycles after start.
  - 24 back-to-back bytes.
- freq=17_179_869_183, duty=255 → frame "F=17179869183Hz D=255%\r\n".
- freq=0, duty=0:
  - Macro undefined → "F=00000000000Hz D=000%\r\n".
  - Macro defined → "F=" + 10 spaces + "0Hz D=000%\r\n".
- freq=1234, duty=33, tx_ready randomly toggled → identical frame.
  - tx_data and tx_valid are held stable on every stalled cycle.
- Start with freq=100, then change freq to 999 and pulse start again during CONV_D and during EMIT → exactly one frame, containing "00000000100".
- rst_n low for one cycle during EMIT at byte 10 → the next cycle shows tx_valid=0 and busy=0.
  - A new start then yields a complete frame beginning at "F".

Source files
------------

// File: rtl/freq_fmt_pkg.sv
// freq_fmt_pkg
// Shared definitions for freq_ascii_framer: FSM state encoding, frame
// length and the ASCII constants used to build the text frame.
package freq_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV_F,
    CONV_D,
    EMIT
  } state_t;

  localparam int FRAME_LEN = 24;

  localparam logic [7:0] ASC_F   = 8'h46;
  localparam logic [7:0] ASC_EQ  = 8'h3D;
  localparam logic [7:0] ASC_H   = 8'h48;
  localparam logic [7:0] ASC_Z   = 8'h7A;
  localparam logic [7:0] ASC_SP  = 8'h20;
  localparam logic [7:0] ASC_D   = 8'h44;
  localparam logic [7:0] ASC_PCT = 8'h25;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_0   = 8'h30;

endpackage

// File: rtl/freq_ascii_framer_bin2bcd.sv
// bin2bcd_seq
// Sequential double-dabble binary to BCD converter, one bit per cycle.
// The operand is taken MSB-first from the top of bin, so shorter values
// are loaded left-aligned and converted in nbits cycles.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load        start a conversion of bin over its top nbits bits
//   bin         operand, left-aligned
//   nbits       number of operand bits to convert (>= 1)
//   busy        conversion still in progress
//   bcd         packed BCD result, digit 0 in the low nibble
module bin2bcd_seq #(
  parameter int W      = 34,
  parameter int DIGITS = 11,
  parameter int CW     = $clog2(W + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [W-1:0]          bin,
  input  logic [CW-1:0]         nbits,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [W-1:0]        sh;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // The load cycle already shifts in the first bit: with an all-zero BCD
  // register no nibble needs adjusting, so an nbits conversion finishes
  // nbits-1 cycles after load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
      bcd <= '0;
    end else if (load) begin
      bcd <= {{(4*DIGITS-1){1'b0}}, bin[W-1]};
      sh  <= bin << 1;
      cnt <= nbits - 1'b1;
    end else if (cnt != '0) begin
      bcd <= {bcd_adj[4*DIGITS-2:0], sh[W-1]};
      sh  <= sh << 1;
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/freq_ascii_framer.sv
// freq_ascii_framer
// Captures one frequency/duty result on start, converts both to ASCII
// decimal and streams a 24-byte frame "F=<11 digits>Hz D=<3 digits>%\r\n"
// over a valid/ready byte interface.
// Optional feature macro FREQ_ZERO_SUPPRESS_EN: leading zero frequency
// digits are sent as spaces (the last digit is always numeric).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       one-cycle request to send a frame (ignored while busy)
//   freq, duty  measurement inputs, sampled on the accepted start
//   busy        high while converting or emitting
//   tx_data     ASCII byte, tx_valid/tx_ready handshake
//
// state  | meaning
// IDLE   | waiting for start
// CONV_F | converting captured frequency (FREQ_W cycles)
// CONV_D | converting captured duty (DUTY_W cycles)
// EMIT   | presenting frame bytes until byte 23 is accepted
module freq_ascii_framer
  import freq_fmt_pkg::*;
#(
  parameter int FREQ_W      = 34,
  parameter int DUTY_W      = 8,
  parameter int FREQ_DIGITS = 11,
  parameter int DUTY_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FREQ_W-1:0] freq,
  input  logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int FD = FREQ_DIGITS;
  localparam int DD = DUTY_DIGITS;
  localparam int CW = $clog2(FREQ_W + 1);
  localparam int IW = $clog2(FRAME_LEN);

  state_t              state;
  logic [IW-1:0]       idx;
  logic [DUTY_W-1:0]   duty_cap;
  logic [4*FD-1:0]     freq_bcd;
  logic [4*DD-1:0]     duty_bcd;

  logic                conv_load;
  logic [FREQ_W-1:0]   conv_bin;
  logic [CW-1:0]       conv_nbits;
  logic                conv_busy;
  logic [4*FD-1:0]     conv_bcd;

  logic [FD-1:0]       supp;
  logic [7:0]          byte_nxt;
  int                  sel;
  int                  dig;

  // Frequency goes straight into the converter's shift register on the
  // start edge, so it is the captured copy; duty waits in duty_cap.
  always_comb begin
    conv_load  = 1'b0;
    conv_bin   = freq;
    conv_nbits = CW'(FREQ_W);
    case (state)
      IDLE:    conv_load = start;
      CONV_F: begin
        conv_load  = !conv_busy;
        conv_bin   = FREQ_W'(duty_cap) << (FREQ_W - DUTY_W);
        conv_nbits = CW'(DUTY_W);
      end
      default: conv_load = 1'b0;
    endcase
  end

  bin2bcd_seq #(
    .W      (FREQ_W),
    .DIGITS (FD),
    .CW     (CW)
  ) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (conv_load),
    .bin   (conv_bin),
    .nbits (conv_nbits),
    .busy  (conv_busy),
    .bcd   (conv_bcd)
  );

`ifdef FREQ_ZERO_SUPPRESS_EN
  logic lead;
  always_comb begin
    supp = '0;
    lead = 1'b1;
    for (int k = FD - 1; k >= 1; k--) begin
      lead    = lead && (freq_bcd[4*k +: 4] == 4'd0);
      supp[k] = lead;
    end
  end
`else
  always_comb supp = '0;
`endif

  // Byte for the next index, registered into tx_data on each advance.
  always_comb begin
    sel      = (state == EMIT) ? int'(idx) + 1 : 0;
    dig      = 0;
    byte_nxt = 8'h00;
    if (sel == 0)                 byte_nxt = ASC_F;
    else if (sel == 1)            byte_nxt = ASC_EQ;
    else if (sel < FD + 2) begin
      dig      = FD + 1 - sel;
      byte_nxt = supp[dig] ? ASC_SP : ASC_0 + {4'h0, freq_bcd[4*dig +: 4]};
    end
    else if (sel == FD + 2)       byte_nxt = ASC_H;
    else if (sel == FD + 3)       byte_nxt = ASC_Z;
    else if (sel == FD + 4)       byte_nxt = ASC_SP;
    else if (sel == FD + 5)       byte_nxt = ASC_D;
    else if (sel == FD + 6)       byte_nxt = ASC_EQ;
    else if (sel < FD + DD + 7) begin
      dig      = FD + DD + 6 - sel;
      byte_nxt = ASC_0 + {4'h0, duty_bcd[4*dig +: 4]};
    end
    else if (sel == FD + DD + 7)  byte_nxt = ASC_PCT;
    else if (sel == FD + DD + 8)  byte_nxt = ASC_CR;
    else if (sel == FD + DD + 9)  byte_nxt = ASC_LF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      idx      <= '0;
      duty_cap <= '0;
      freq_bcd <= '0;
      duty_bcd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            duty_cap <= duty;
            busy     <= 1'b1;
            state    <= CONV_F;
          end
        end
        CONV_F: begin
          if (!conv_busy) begin
            freq_bcd <= conv_bcd;
            state    <= CONV_D;
          end
        end
        CONV_D: begin
          if (!conv_busy) begin
            duty_bcd <= conv_bcd[4*DD-1:0];
            idx      <= '0;
            tx_data  <= byte_nxt;
            tx_valid <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (tx_ready) begin
            if (idx == IW'(FRAME_LEN - 1)) begin
              idx      <= '0;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              idx     <= idx + 1'b1;
              tx_data <= byte_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
